// File: rtl/data_mem_lsu.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | data_mem_lsu : word-organised data memory with RISC-V style load/store    |
// |                unit, fixed load latency and size/alignment error checks.  |
// | Revision     : 1.0                                                        |
// +---------------------------------------------------------------------------+
module data_mem_lsu #(
   parameter int DM_ADDRESS = 9,
   parameter int RD_LAT     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [2:0]            req_funct3,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int         c_WORDS    = 2 ** (DM_ADDRESS - 2);
   localparam logic [1:0] c_CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  we_q;
   logic                  err_q;
   logic [1:0]            lane_q;
   logic [2:0]            f3_q;
   logic [DM_ADDRESS-3:0] widx_q;

   logic [31:0] mem_q [c_WORDS] = '{default: '0};

   logic        w_accept;
   logic        w_illegal;
   logic        w_misalign;
   logic        w_err;
   logic        w_store;
   logic [3:0]  w_be;
   logic [31:0] w_wlanes;
   logic [31:0] w_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;

   assign w_accept = req_valid && req_ready;

   always_comb begin
      w_illegal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
         3'b100, 3'b101:         w_illegal = req_we;
         default:                w_illegal = 1'b1;
      endcase
   end

   assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_err      = w_illegal || w_misalign;
   assign w_store    = w_accept && req_we && !w_err;

   // Replicate the store data across lanes so each enabled lane picks its own copy.
   always_comb begin
      w_be     = 4'b1111;
      w_wlanes = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            w_be     = 4'b0001 << req_addr[1:0];
            w_wlanes = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be     = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{req_wdata[15:0]}};
         end
         default: begin
            w_be     = 4'b1111;
            w_wlanes = req_wdata;
         end
      endcase
   end

   // Memory has no reset: contents survive reset assertion.
   always_ff @(posedge clk) begin
      if (w_store) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               mem_q[req_addr[DM_ADDRESS-1:2]][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         lane_q  <= 2'd0;
         f3_q    <= 3'd0;
         widx_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (w_accept) begin
            we_q   <= req_we;
            err_q  <= w_err;
            lane_q <= req_addr[1:0];
            f3_q   <= req_funct3;
            widx_q <= req_addr[DM_ADDRESS-1:2];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (w_accept) begin
               if (req_we || w_err || (RD_LAT == 1)) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = c_CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign w_word = mem_q[widx_q];
   assign w_byte = w_word[{lane_q, 3'b000} +: 8];
   assign w_half = w_word[{lane_q[1], 4'b0000} +: 16];

   always_comb begin
      w_load = 32'd0;
      case (f3_q)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'd0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'd0, w_half};
         3'b010:  w_load = w_word;
         default: w_load = 32'd0;
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = (state_q == RESP) && err_q;
   assign rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? w_load : 32'd0;

endmodule
`default_nettype wire
